// File: rtl/edf_queue_scheduler_pkg.sv
// edf_queue_scheduler_pkg: fetch-state type and label helpers shared by the EDF scheduler.
package edf_sched_pkg;
  typedef enum logic [1:0] {F_IDLE, F_RD, F_WAITV, F_SETTLE} fetch_state_t;
  function automatic logic [31:0] label_of(input logic [63:0] data, input int unsigned dw, input int unsigned lw);
    return 32'(data >> (dw - lw)) & ((32'd1 << lw) - 32'd1);
  endfunction
  // Modular compare treats labels as points on a ring, so deadlines survive counter wrap.
  function automatic logic label_earlier(input logic [31:0] a, input logic [31:0] b, input logic wrap, input int unsigned w);
    return wrap ? ((((a - b) >> (w - 1)) & 32'd1) != 32'd0) : (a < b);
  endfunction
endpackage

// File: rtl/edf_stage_ctrl.sv
// edf_stage_ctrl: one queue's read sequencer, timeout counter and prefetch stage register.
module edf_stage_ctrl
  import edf_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sched_en,
  input  logic                  q_empty,
  input  logic                  q_valid,
  input  logic [DATA_WIDTH-1:0] q_dout,
  input  logic                  take,
  output logic                  q_re,
  output logic                  stage_vld,
  output logic [DATA_WIDTH-1:0] stage,
  output logic                  timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  fetch_state_t state;
  logic [CW-1:0] cnt;
  logic valid_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= F_IDLE;
      cnt       <= '0;
      valid_q   <= 1'b0;
      q_re      <= 1'b0;
      stage_vld <= 1'b0;
      stage     <= '0;
      timeout   <= 1'b0;
    end else begin
      valid_q <= q_valid;
      q_re    <= 1'b0;
      timeout <= 1'b0;
      if (take) stage_vld <= 1'b0;
      case (state)
        F_IDLE: if (sched_en && !q_empty && !stage_vld && !q_valid) begin
          state <= F_RD;
          q_re  <= 1'b1;
        end
        F_RD: begin
          state <= F_WAITV;
          cnt   <= '0;
        end
        F_WAITV: if (q_valid && !valid_q) begin
          stage     <= q_dout;
          stage_vld <= 1'b1;
          state     <= F_SETTLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout <= 1'b1;
          state   <= F_IDLE;
        end else cnt <= cnt + 1'b1;
        F_SETTLE: if (!q_valid) state <= F_IDLE;
        default: state <= F_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/edf_queue_scheduler.sv
// edf_queue_scheduler: prefetches heap-queue heads and forwards the earliest-deadline entry downstream.
module edf_queue_scheduler
  import edf_sched_pkg::*;
#(
  parameter int NUM_QUEUES   = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int LABEL_WIDTH  = 8,
  parameter int WRAP_COMPARE = 1,
  parameter int TIMEOUT      = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sched_en,
  input  logic [NUM_QUEUES-1:0]            q_empty,
  input  logic [NUM_QUEUES-1:0]            q_valid,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_dout,
  output logic [NUM_QUEUES-1:0]            q_re,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [$clog2(NUM_QUEUES)-1:0]    out_src,
  output logic [NUM_QUEUES-1:0]            err_timeout,
  input  logic                             err_clr
);
  localparam int SW = $clog2(NUM_QUEUES);
  logic [NUM_QUEUES-1:0] stage_vld, take, tmo;
  logic [DATA_WIDTH-1:0] stage [NUM_QUEUES];
  logic [SW-1:0] rr_ptr, win, idx;
  logic any, load;
  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_q
    edf_stage_ctrl #(.DATA_WIDTH(DATA_WIDTH), .TIMEOUT(TIMEOUT)) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .sched_en (sched_en),
      .q_empty  (q_empty[i]),
      .q_valid  (q_valid[i]),
      .q_dout   (q_dout[i*DATA_WIDTH +: DATA_WIDTH]),
      .take     (take[i]),
      .q_re     (q_re[i]),
      .stage_vld(stage_vld[i]),
      .stage    (stage[i]),
      .timeout  (tmo[i])
    );
  end
  // Scanning from rr_ptr and replacing only on strictly-earlier labels gives the circular tie-break.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      idx = SW'((int'(rr_ptr) + k) % NUM_QUEUES);
      if (stage_vld[idx] && (!any || label_earlier(label_of(64'(stage[idx]), DATA_WIDTH, LABEL_WIDTH),
          label_of(64'(stage[win]), DATA_WIDTH, LABEL_WIDTH), WRAP_COMPARE != 0, LABEL_WIDTH))) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  assign load = (!out_valid || out_ready) && any;
  assign take = {NUM_QUEUES{load}} & (NUM_QUEUES'(1) << win);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_src     <= '0;
      rr_ptr      <= '0;
      err_timeout <= '0;
    end else begin
      err_timeout <= (err_clr ? '0 : err_timeout) | tmo;
      if (!out_valid || out_ready) out_valid <= any;
      if (load) begin
        out_data <= stage[win];
        out_src  <= win;
        rr_ptr   <= (win == SW'(NUM_QUEUES - 1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_edf_queue_scheduler.sv
// tb_edf_queue_scheduler: two schedulers (modular and plain compare) fed by behavioural heap queues.
module tb_edf_queue_scheduler;
  localparam int SETTLE = 3;
  logic clk = 1'b0, rst = 1'b1, sched_en = 1'b1, err_clr = 1'b0;
  always #5 clk = ~clk;
  logic [3:0]  q_empty [2], q_valid [2], q_re [2], err [2];
  logic [63:0] q_dout [2];
  logic        rdy [2], out_valid [2];
  logic [15:0] out_data [2];
  logic [1:0]  out_src [2];
  for (genvar d = 0; d < 2; d++) begin : g_dut
    edf_queue_scheduler #(.NUM_QUEUES(4), .DATA_WIDTH(16), .LABEL_WIDTH(8), .WRAP_COMPARE(d), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .sched_en(sched_en), .q_empty(q_empty[d]), .q_valid(q_valid[d]),
      .q_dout(q_dout[d]), .q_re(q_re[d]), .out_valid(out_valid[d]), .out_ready(rdy[d]),
      .out_data(out_data[d]), .out_src(out_src[d]), .err_timeout(err[d]), .err_clr(err_clr));
  end
  int mem [2][4][8];
  int cnt [2][4], hold [2][4];
  bit stub [2][4], pend [2][4];
  logic [15:0] popped [2][4];
  int log_src [2][16], log_lab [2][16], log_n [2];
  int busy_err = 0, re_cnt = 0, re_any = 0, nchk = 0, nerr = 0;
  typedef struct {
    int cnt [4];
    int lab [4][3];
    int n;
    int src [2][8];
    int elab [2][8];
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    int m;
    for (int d = 0; d < 2; d++) begin
      if (out_valid[d] && rdy[d] && log_n[d] < 16) begin
        log_src[d][log_n[d]] = int'(out_src[d]);
        log_lab[d][log_n[d]] = int'(out_data[d][15:8]);
        log_n[d]++;
      end
      for (int q = 0; q < 4; q++) if (q_re[d][q] && q_valid[d][q]) busy_err++;
    end
    if (q_re[1][2]) re_cnt++;
    re_any += $countones(q_re[1]);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int q = 0; q < 4; q++) begin
        if (q_valid[d][q]) begin
          if (hold[d][q] == 0) q_valid[d][q] = 1'b0;
          else hold[d][q]--;
        end else if (pend[d][q]) begin
          pend[d][q] = 1'b0;
          q_valid[d][q] = 1'b1;
          q_dout[d][q*16 +: 16] = popped[d][q];
          hold[d][q] = SETTLE - 1;
        end
        if (q_re[d][q] && !stub[d][q] && cnt[d][q] > 0) begin
          m = 0;
          for (int k = 1; k < cnt[d][q]; k++) if ((mem[d][q][k] >> 8) < (mem[d][q][m] >> 8)) m = k;
          popped[d][q] = 16'(mem[d][q][m]);
          mem[d][q][m] = mem[d][q][cnt[d][q]-1];
          cnt[d][q]--;
          pend[d][q] = 1'b1;
        end
        q_empty[d][q] = (cnt[d][q] == 0);
      end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    err_clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      q_valid[d] = '0;
      q_empty[d] = '1;
      q_dout[d] = '0;
      log_n[d] = 0;
      rdy[d] = 1'b1;
      for (int k = 0; k < 16; k++) begin
        log_src[d][k] = -1;
        log_lab[d][k] = -1;
      end
      for (int q = 0; q < 4; q++) begin
        cnt[d][q] = 0;
        hold[d][q] = 0;
        stub[d][q] = 1'b0;
        pend[d][q] = 1'b0;
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst q_re d%0d", d), int'(q_re[d]), 0);
      chk($sformatf("rst out_valid d%0d", d), int'(out_valid[d]), 0);
      chk($sformatf("rst out_data d%0d", d), int'(out_data[d]), 0);
      chk($sformatf("rst out_src d%0d", d), int'(out_src[d]), 0);
      chk($sformatf("rst err d%0d", d), int'(err[d]), 0);
    end
  endtask

  task automatic load(input int d, input int q, input int lab);
    mem[d][q][cnt[d][q]] = (lab << 8) | (q * 16 + cnt[d][q]);
    cnt[d][q]++;
  endtask

  task automatic run_vec(input int v);
    apply_reset();
    for (int d = 0; d < 2; d++)
      for (int q = 0; q < 4; q++)
        for (int k = 0; k < vt[v].cnt[q]; k++) load(d, q, vt[v].lab[q][k]);
    rst = 1'b0;
    for (int t = 0; t < 300 && !(log_n[0] >= vt[v].n && log_n[1] >= vt[v].n); t++) tick();
    repeat (20) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("v%0d d%0d count", v, d), log_n[d], vt[v].n);
      for (int k = 0; k < vt[v].n; k++) begin
        chk($sformatf("v%0d d%0d src%0d", v, d, k), log_src[d][k], vt[v].src[d][k]);
        chk($sformatf("v%0d d%0d lab%0d", v, d, k), log_lab[d][k], vt[v].elab[d][k]);
      end
    end
  endtask

  initial begin
    logic [15:0] snap;
    int changes;
    int exp_src [5], exp_lab [5];
    vt[0].cnt = '{3, 0, 0, 0};
    vt[0].lab = '{'{5, 2, 9}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    vt[0].n = 3;
    vt[0].src[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[0].elab[0] = '{2, 5, 9, 0, 0, 0, 0, 0};
    vt[1].cnt = '{1, 1, 1, 0};
    vt[1].lab = '{'{'h30, 0, 0}, '{'h10, 0, 0}, '{'h20, 0, 0}, '{0, 0, 0}};
    vt[1].n = 3;
    vt[1].src[0] = '{1, 2, 0, 0, 0, 0, 0, 0};
    vt[1].elab[0] = '{'h10, 'h20, 'h30, 0, 0, 0, 0, 0};
    vt[2].cnt = '{2, 2, 2, 2};
    vt[2].lab = '{'{7, 7, 0}, '{7, 7, 0}, '{7, 7, 0}, '{7, 7, 0}};
    vt[2].n = 8;
    vt[2].src[0] = '{0, 1, 2, 3, 0, 1, 2, 3};
    vt[2].elab[0] = '{7, 7, 7, 7, 7, 7, 7, 7};
    for (int v = 0; v < 3; v++) begin
      vt[v].src[1] = vt[v].src[0];
      vt[v].elab[1] = vt[v].elab[0];
    end
    vt[3].cnt = '{1, 1, 0, 0};
    vt[3].lab = '{'{'hFE, 0, 0}, '{'h02, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    vt[3].n = 2;
    vt[3].src[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    vt[3].elab[0] = '{'h02, 'hFE, 0, 0, 0, 0, 0, 0};
    vt[3].src[1] = '{0, 1, 0, 0, 0, 0, 0, 0};
    vt[3].elab[1] = '{'hFE, 'h02, 0, 0, 0, 0, 0, 0};
    vt[4].cnt = '{0, 1, 1, 1};
    vt[4].lab = '{'{0, 0, 0}, '{'h05, 0, 0}, '{'h10, 0, 0}, '{'hF0, 0, 0}};
    vt[4].n = 3;
    vt[4].src[0] = '{1, 2, 3, 0, 0, 0, 0, 0};
    vt[4].elab[0] = '{'h05, 'h10, 'hF0, 0, 0, 0, 0, 0};
    vt[4].src[1] = '{3, 1, 2, 0, 0, 0, 0, 0};
    vt[4].elab[1] = '{'hF0, 'h05, 'h10, 0, 0, 0, 0, 0};
    for (int v = 0; v < 5; v++) run_vec(v);
    // Backpressure: everything staged, output frozen, then drains one per cycle.
    apply_reset();
    for (int d = 0; d < 2; d++)
      for (int q = 0; q < 4; q++)
        for (int k = 0; k < 3; k++) load(d, q, (q == 0 ? 'h40 : q * 'h10) + k);
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    rst = 1'b0;
    repeat (25) tick();
    chk("stall valid", int'(out_valid[1]), 1);
    chk("stall src", int'(out_src[1]), 1);
    chk("stall lab", int'(out_data[1][15:8]), 'h10);
    snap = out_data[1];
    changes = 0;
    re_any = 0;
    repeat (10) begin
      tick();
      if (out_data[1] != snap || out_src[1] != 2'd1 || !out_valid[1]) changes++;
    end
    chk("stall stable", changes, 0);
    chk("stall no re", re_any, 0);
    rdy[1] = 1'b1;
    log_n[1] = 0;
    repeat (5) tick();
    exp_src = '{1, 1, 2, 3, 0};
    exp_lab = '{'h10, 'h11, 'h20, 'h30, 'h40};
    chk("drain count", log_n[1], 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain src%0d", k), log_src[1][k], exp_src[k]);
      chk($sformatf("drain lab%0d", k), log_lab[1][k], exp_lab[k]);
    end
    // Stub queue that never answers: timeout, retry, clear, then async reset mid-wait.
    apply_reset();
    for (int d = 0; d < 2; d++) begin
      load(d, 0, 'h33);
      load(d, 2, 'h55);
      stub[d][2] = 1'b1;
      rdy[d] = 1'b0;
    end
    rst = 1'b0;
    re_cnt = 0;
    repeat (40) tick();
    chk("tmo early err", int'(err[1]), 0);
    chk("tmo first re", re_cnt, 1);
    chk("tmo out_valid", int'(out_valid[1]), 1);
    repeat (40) tick();
    chk("tmo err set", int'(err[1]), 4'b0100);
    chk("tmo retry re", re_cnt, 2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo err clr", int'(err[1]), 0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async q_re", int'(q_re[1]), 0);
    chk("async out_valid", int'(out_valid[1]), 0);
    chk("async out_data", int'(out_data[1]), 0);
    chk("re while valid", busy_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
